// File: rtl/ysyx_22041071_div_ctrl_if.sv
// Request, response and divider-side signals of the divide controller.
// The controller uses the slave view; EX stage and divider together form the master view.
interface ysyx_22041071_div_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic [RD_W-1:0]   in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              busy;
    logic              div_valid_o;
    logic              div_signed_o;
    logic              divw_o;
    logic              div_flush_o;
    logic [DATA_W-1:0] dividend_o;
    logic [DATA_W-1:0] divisor_o;
    logic              div_ready_i;
    logic              div_out_valid_i;
    logic [DATA_W-1:0] div_quot_i;
    logic [DATA_W-1:0] div_rema_i;

    modport slave (
        input  flush, in_valid, in_op, in_src1, in_src2, in_rd, out_ready,
               div_ready_i, div_out_valid_i, div_quot_i, div_rema_i,
        output in_ready, out_valid, out_result, out_rd, busy,
               div_valid_o, div_signed_o, divw_o, div_flush_o, dividend_o, divisor_o
    );

    modport master (
        output flush, in_valid, in_op, in_src1, in_src2, in_rd, out_ready,
               div_ready_i, div_out_valid_i, div_quot_i, div_rema_i,
        input  in_ready, out_valid, out_result, out_rd, busy,
               div_valid_o, div_signed_o, divw_o, div_flush_o, dividend_o, divisor_o
    );
endinterface

// File: rtl/ysyx_22041071_div_ctrl.sv
// RV64M divide sequencer: div-by-zero/overflow (and cache hits) answered in 1 cycle, else divider latency + 1.
// One request in flight; in_ready only in IDLE, result held until out_ready; flush drains the divider.
// Optional result cache of the last divider operation: YSYX_22041071_DIV_CACHE_EN.
module ysyx_22041071_div_ctrl #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    ysyx_22041071_div_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_DRAIN} state_t;

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] sext_w(input logic [DATA_W-1:0] v, input logic word);
        sext_w = word ? {{(DATA_W-32){v[31]}}, v[31:0]} : v;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [DATA_W-1:0] r_result;
    logic [2:0]        r_op;
    logic [RD_W-1:0]   r_rd;

    logic              w_accept;
    logic              w_capture;
    logic              w_word;
    logic              w_uns;
    logic              w_rem;
    logic [DATA_W-1:0] w_eff2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_res;
    logic              w_fast;
    logic [DATA_W-1:0] w_fast_res;
    logic              w_div_valid;
    logic              w_div_flush;

    assign w_word = bus.in_op[2];
    assign w_uns  = bus.in_op[0];
    assign w_rem  = bus.in_op[1];
    assign w_eff2 = w_word ? {{(DATA_W-32){1'b0}}, bus.in_src2[31:0]} : bus.in_src2;
    assign w_div0 = (w_eff2 == '0);
    assign w_ovf  = !w_uns && (w_word ?
                    (bus.in_src1[31:0] == 32'h8000_0000 && bus.in_src2[31:0] == 32'hFFFF_FFFF) :
                    (bus.in_src1 == MOST_NEG && bus.in_src2 == '1));

`ifdef YSYX_22041071_DIV_CACHE_EN
    logic              r_c_vld;
    logic              r_c_signed;
    logic              r_c_word;
    logic [DATA_W-1:0] r_c_src1;
    logic [DATA_W-1:0] r_c_src2;
    logic [DATA_W-1:0] r_c_quot;
    logic [DATA_W-1:0] r_c_rema;

    // Survives flush on purpose: the entry is a completed divider result, not pipeline state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_vld    <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_word   <= 1'b0;
            r_c_src1   <= '0;
            r_c_src2   <= '0;
            r_c_quot   <= '0;
            r_c_rema   <= '0;
        end else if (w_capture) begin
            r_c_vld    <= 1'b1;
            r_c_signed <= ~r_op[0];
            r_c_word   <= r_op[2];
            r_c_src1   <= r_src1;
            r_c_src2   <= r_src2;
            r_c_quot   <= bus.div_quot_i;
            r_c_rema   <= bus.div_rema_i;
        end
    end

    assign w_hit = r_c_vld && (bus.in_src1 == r_c_src1) && (bus.in_src2 == r_c_src2) &&
                   (r_c_signed == !w_uns) && (r_c_word == w_word);
    assign w_hit_res = w_rem ? r_c_rema : r_c_quot;
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    // Div-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
    always_comb begin
        w_fast_res = '0;
        if (w_div0)
            w_fast_res = sext_w(w_rem ? bus.in_src1 : '1, w_word);
        else if (w_ovf)
            w_fast_res = sext_w(w_rem ? '0 : bus.in_src1, w_word);
        else
            w_fast_res = sext_w(w_hit_res, w_word);
    end

    assign w_fast    = w_div0 || w_ovf || w_hit;
    assign w_accept  = bus.in_valid && (r_state == S_IDLE) && !bus.flush;
    assign w_capture = (r_state == S_BUSY) && !bus.flush && bus.div_out_valid_i;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_valid = 1'b0;
        w_div_flush = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_fast ? S_RESP : S_BUSY;
            end
            S_BUSY: begin
                if (bus.flush) begin
                    w_state_nxt = S_DRAIN;
                    w_div_flush = 1'b1;
                end else begin
                    w_div_valid = 1'b1;
                    if (bus.div_out_valid_i) w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.flush || bus.out_ready) w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                w_div_flush = 1'b1;
                if (bus.div_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src1   <= '0;
            r_src2   <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_src1 <= bus.in_src1;
                r_src2 <= bus.in_src2;
                r_op   <= bus.in_op;
                r_rd   <= bus.in_rd;
                if (w_fast) r_result <= w_fast_res;
            end
            if (w_capture)
                r_result <= sext_w(r_op[1] ? bus.div_rema_i : bus.div_quot_i, r_op[2]);
        end
    end

    assign bus.in_ready     = (r_state == S_IDLE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.out_valid    = (r_state == S_RESP);
    assign bus.out_result   = r_result;
    assign bus.out_rd       = r_rd;
    assign bus.div_valid_o  = w_div_valid;
    assign bus.div_flush_o  = w_div_flush;
    assign bus.dividend_o   = r_src1;
    assign bus.divisor_o    = r_src2;
    // Gated so the signedness line reads 0 out of reset while r_op is all zeros.
    assign bus.div_signed_o = (r_state == S_BUSY) && !r_op[0];
    assign bus.divw_o       = r_op[2];
endmodule

// File: doc/ysyx_22041071_div_ctrl.md
# ysyx_22041071_div_ctrl

Sequencing controller between the EX stage and the 64-bit iterative divider. Accepts one RV64M divide/remainder request at a time and resolves divide-by-zero and signed overflow without launching the divider. Otherwise it holds the divider's operands stable for the whole operation, selects quotient or remainder, and sign-extends W-form results. It also absorbs pipeline flushes by draining the divider before accepting new work.

## Interface
- DATA_W, 64: operand/result width; only 64 is supported.
- RD_W, 5: width of the destination tag carried alongside the request.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  cancel the in-flight or pending request.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_op  in  3  bit0 = unsigned, bit1 = remainder, bit2 = word (W) form.
- in_src1  in  DATA_W  dividend.
- in_src2  in  DATA_W  divisor.
- in_rd  in  RD_W  destination tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  final result.
- out_rd  out  RD_W  tag of the result.
- busy  out  1  state != IDLE, used for hazard stall.
- div_valid_o  out  1  to divider div_valid.
- div_signed_o  out  1  to divider div_signed.
- divw_o  out  1  to divider divw.
- div_flush_o  out  1  to divider flush.
- dividend_o  out  DATA_W  to divider dividend.
- divisor_o  out  DATA_W  to divider divisor.
- div_ready_i  in  1  divider is idle.
- div_out_valid_i  in  1  divider one-cycle done pulse.
- div_quot_i  in  DATA_W  divider quotient.
- div_rema_i  in  DATA_W  divider remainder.

## Operation
- States and meaning:
  - IDLE: waiting for a request.
  - BUSY: divider operation in flight.
  - RESP: result held for the consumer.
  - DRAIN: waiting for an aborted divider operation to finish.
- in_ready = (state == IDLE). A request is accepted when in_valid & in_ready & !flush.
- On accept, register src1, src2, op and rd.
- W form takes operands from bits [31:0]. Special cases are evaluated on the effective width.
- Divide-by-zero (effective divisor == 0):
  - quotient = all ones;
  - remainder = effective dividend.
- Signed overflow (signed, dividend = most negative value, divisor = -1):
  - quotient = dividend;
  - remainder = 0.
- Special case on accept → RESP. The result is computed and registered on the accept edge, and the divider is never launched.
- Otherwise on accept → BUSY.
- BUSY behaviour:
  - div_valid_o = !flush. dividend_o, divisor_o, div_signed_o = !op[0] and divw_o = op[2] are driven from registers and stay constant until the divider's done pulse.
  - When div_out_valid_i is seen, capture div_rema_i if op[1] is set, else div_quot_i, and go to RESP.
- W form: the result is bits [31:0] sign-extended from bit 31. This also applies to the special-case results.
- RESP: out_valid = 1. out_result and out_rd are held stable until out_valid & out_ready, then → IDLE.
- Flush handling:
  - IDLE: no state change; a request presented in the same cycle is dropped.
  - BUSY: → DRAIN; div_valid_o = 0 and div_flush_o = 1 in that cycle. Flush wins over a simultaneous div_out_valid_i.
  - RESP: → IDLE; the result is discarded and out_valid drops next cycle.
- DRAIN: div_valid_o = 0, div_flush_o = 1. Go to IDLE in the cycle after div_ready_i = 1 is seen.
- div_flush_o = 0 in every cycle not listed under flush handling.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1 and busy = 0;
  - out_valid = 0, out_result = 0, out_rd = 0;
  - div_valid_o = 0, div_flush_o = 0, dividend_o = 0, divisor_o = 0, div_signed_o = 0, divw_o = 0;
  - cache invalid.
- A reset asserted mid-operation returns the controller to these values on the next edge; no drain is performed. The divider is reset by the same signal.
- Accept at edge T:
  - special case: out_valid from cycle T+1;
  - normal case: div_valid_o from T+1; divider done pulse in cycle D; out_valid from D+1.
- There is at most one request in flight; in_ready stays 0 from accept until the RESP handshake or flush.
- out_valid, out_result and out_rd depend only on registers.

## Configuration
- YSYX_22041071_DIV_CACHE_EN defined:
  - Store the last divider-computed {src1, src2, signed, word, quotient, remainder} plus a valid bit.
  - A request matching src1, src2, signed and word goes IDLE → RESP with the cached quotient or remainder selected by op[1]. out_valid is asserted at T+1 and the divider is not launched.
  - The cache fills on div_out_valid_i in BUSY. It is cleared only by reset; flush does not clear it.
- Macro undefined: no cache logic. Every non-special request uses the divider.

## Test plan
- DIV, src1 = 100, src2 = -7 → divider launched once; out_result = 0xFFFFFFFFFFFFFFF2 (-14) one cycle after the done pulse.
- REMU, src1 = 0x1234, src2 = 0 → out_result = 0x1234 at T+1; div_valid_o never asserted.
- DIVW, src1 = 0x0000000080000000, src2 = 0xFFFFFFFF → overflow path; out_result = 0xFFFFFFFF80000000 at T+1.
- DIVU 1000/3, with flush 20 cycles after launch → div_valid_o drops and div_flush_o = 1. State holds DRAIN until div_ready_i, with no out_valid. A following DIVU 9/2 returns 4.
- DIV 50/5 with out_ready low for 5 cycles after out_valid → out_result = 10 and out_rd stay stable; in_ready = 0; handshake on cycle 6 then in_ready = 1.
- With the cache macro: DIV 1000/3, then REM 1000/3 → second result 1 at T+1 with no divider launch. Without the macro, the same sequence relaunches the divider and still returns 1.
